// File: rtl/serdes_pkg.sv
// Types shared by the deserializer and serializer front-ends of the FFT datapath.
package serdes_pkg;

  typedef enum logic {RECV, SEND} deser_state_t;

endpackage

// File: rtl/deserializer_if.sv
// Val/rdy stream-in / frame-out bundle for the deserializer.
interface deserializer_if #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
);

  logic [BIT_WIDTH-1:0] recv_msg;
  logic                 recv_val;
  logic                 recv_rdy;
  logic [BIT_WIDTH-1:0] send_msg [N_SAMPLES];
  logic                 send_val;
  logic                 send_rdy;

  modport master (
    output recv_msg, recv_val, send_rdy,
    input  recv_rdy, send_msg, send_val
  );

  modport slave (
    input  recv_msg, recv_val, send_rdy,
    output recv_rdy, send_msg, send_val
  );

endinterface

// File: rtl/deserializer_sample_reg.sv
// One sample slot of the frame buffer: clears on reset, loads when enabled.
module deserializer_sample_reg #(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_i,
  input  logic [BIT_WIDTH-1:0] d_i,
  output logic [BIT_WIDTH-1:0] q_o
);

  logic [BIT_WIDTH-1:0] data_q;
  logic [BIT_WIDTH-1:0] data_d;

  assign data_d = en_i ? d_i : data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/deserializer.sv
// Gathers N_SAMPLES stream words into one parallel frame; no new words accepted
// while a frame is waiting for the downstream FFT.
module deserializer
  import serdes_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
) (
  input logic           clk,
  input logic           reset,
  deserializer_if.slave bus
);

  localparam int            CW   = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_SAMPLES - 1);

  deser_state_t         state_q;
  logic [CW-1:0]        count_q;
  logic                 recv_rdy_q;
  logic                 send_val_q;
  logic                 recv_xfer;
  logic                 send_xfer;
  logic [BIT_WIDTH-1:0] sample_q [N_SAMPLES];

  // Ready/valid come straight from flops, so neither depends on the peer's val.
  assign recv_xfer = bus.recv_val & recv_rdy_q;
  assign send_xfer = bus.send_rdy & send_val_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RECV;
      count_q    <= '0;
      recv_rdy_q <= 1'b1;
      send_val_q <= 1'b0;
    end else begin
      case (state_q)
        RECV: begin
          if (recv_xfer) begin
            if (count_q == LAST) begin
              count_q    <= '0;
              state_q    <= SEND;
              recv_rdy_q <= 1'b0;
              send_val_q <= 1'b1;
            end else begin
              count_q <= count_q + CW'(1);
            end
          end
        end
        SEND: begin
          if (send_xfer) begin
            state_q    <= RECV;
            recv_rdy_q <= 1'b1;
            send_val_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= RECV;
          recv_rdy_q <= 1'b1;
          send_val_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < N_SAMPLES; i++) begin : g_slot
    deserializer_sample_reg #(
      .BIT_WIDTH(BIT_WIDTH)
    ) u_slot (
      .clk  (clk),
      .reset(reset),
      .en_i (recv_xfer && (count_q == CW'(i))),
      .d_i  (bus.recv_msg),
      .q_o  (sample_q[i])
    );
    assign bus.send_msg[i] = sample_q[i];
  end

  assign bus.recv_rdy = recv_rdy_q;
  assign bus.send_val = send_val_q;

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for the deserializer: 8-sample instance plus a 2-sample instance.
module tb_deserializer;

  logic clk = 1'b0;
  logic reset;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  deserializer_if #(.BIT_WIDTH(32), .N_SAMPLES(8)) r8 ();
  deserializer_if #(.BIT_WIDTH(32), .N_SAMPLES(2)) r2 ();

  deserializer #(.BIT_WIDTH(32), .N_SAMPLES(8)) u_dut8 (
    .clk(clk), .reset(reset), .bus(r8.slave)
  );
  deserializer #(.BIT_WIDTH(32), .N_SAMPLES(2)) u_dut2 (
    .clk(clk), .reset(reset), .bus(r2.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one word and returns one cycle after it was accepted.
  task automatic push8(input logic [31:0] w);
    int t = 0;
    r8.recv_msg = w;
    r8.recv_val = 1'b1;
    while (!r8.recv_rdy && t < 20) begin
      tick();
      t++;
    end
    if (t >= 20) check("push8_timeout", 0, 1);
    tick();
    r8.recv_val = 1'b0;
  endtask

  task automatic push2(input logic [31:0] w);
    int t = 0;
    r2.recv_msg = w;
    r2.recv_val = 1'b1;
    while (!r2.recv_rdy && t < 20) begin
      tick();
      t++;
    end
    if (t >= 20) check("push2_timeout", 0, 1);
    tick();
    r2.recv_val = 1'b0;
  endtask

  task automatic check_frame8(input string tag, input logic [31:0] base);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_msg%0d", tag, i), 64'(r8.send_msg[i]), 64'(base + 32'(i)));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset       = 1'b1;
    r8.recv_msg = '0; r8.recv_val = 1'b0; r8.send_rdy = 1'b0;
    r2.recv_msg = '0; r2.recv_val = 1'b0; r2.send_rdy = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_recv_rdy", 64'(r8.recv_rdy), 1);
    check("rst_send_val", 64'(r8.send_val), 0);
    check("rst_msg0", 64'(r8.send_msg[0]), 0);
    check("rst_msg7", 64'(r8.send_msg[7]), 0);

    // 1. Basic frame, send_rdy=1
    r8.send_rdy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      push8(32'(i));
      if (i < 8) check($sformatf("t1_noval_%0d", i), 64'(r8.send_val), 0);
    end
    check("t1_send_val", 64'(r8.send_val), 1);
    check("t1_recv_rdy", 64'(r8.recv_rdy), 0);
    check_frame8("t1", 32'd1);
    tick();
    check("t1_drop_val", 64'(r8.send_val), 0);
    check("t1_back_rdy", 64'(r8.recv_rdy), 1);

    // 2. Upstream gaps, frame held until released
    r8.send_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push8(32'hA0 + 32'(i));
      if (i < 7) begin
        tick();
        check($sformatf("t2_noval_%0d", i), 64'(r8.send_val), 0);
      end
    end
    check("t2_send_val", 64'(r8.send_val), 1);
    check_frame8("t2", 32'hA0);
    r8.send_rdy = 1'b1;
    tick();
    check("t2_drop_val", 64'(r8.send_val), 0);

    // 3. Back-pressure with an eager upstream
    r8.send_rdy = 1'b0;
    for (int i = 0; i < 8; i++) push8(32'h30 + 32'(i));
    r8.recv_msg = 32'hBAD;
    r8.recv_val = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("t3_val_c%0d", c), 64'(r8.send_val), 1);
      check($sformatf("t3_rdy_c%0d", c), 64'(r8.recv_rdy), 0);
      check($sformatf("t3_msg0_c%0d", c), 64'(r8.send_msg[0]), 64'h30);
      check($sformatf("t3_msg7_c%0d", c), 64'(r8.send_msg[7]), 64'h37);
      tick();
    end
    r8.recv_val = 1'b0;
    r8.send_rdy = 1'b1;
    tick();
    check("t3_drop_val", 64'(r8.send_val), 0);
    check("t3_back_rdy", 64'(r8.recv_rdy), 1);

    // 4. Consecutive frames with one stall cycle between them
    for (int i = 1; i <= 8; i++) push8(32'(i));
    check("t4_f1_val", 64'(r8.send_val), 1);
    check("t4_gap_rdy", 64'(r8.recv_rdy), 0);
    check_frame8("t4_f1", 32'd1);
    tick();
    check("t4_rdy_after_gap", 64'(r8.recv_rdy), 1);
    r8.send_rdy = 1'b0;
    for (int i = 9; i <= 16; i++) push8(32'(i));
    check("t4_f2_val", 64'(r8.send_val), 1);
    check_frame8("t4_f2", 32'd9);
    r8.send_rdy = 1'b1;
    tick();

    // 5. Reset mid-frame discards partial data
    r8.send_rdy = 1'b0;
    for (int i = 0; i < 3; i++) push8(32'h50 + 32'(i));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_rdy", 64'(r8.recv_rdy), 1);
    check("t5_rst_val", 64'(r8.send_val), 0);
    check("t5_rst_msg0", 64'(r8.send_msg[0]), 0);
    for (int i = 0; i < 7; i++) push8(32'h11 + 32'(i));
    check("t5_early_val", 64'(r8.send_val), 0);
    push8(32'h18);
    check("t5_send_val", 64'(r8.send_val), 1);
    check_frame8("t5", 32'h11);
    r8.send_rdy = 1'b1;
    tick();

    // 6. Two-sample instance, two frames to exercise the wrap
    r2.send_rdy = 1'b0;
    push2(32'hDEAD);
    check("t6_mid_val", 64'(r2.send_val), 0);
    push2(32'hBEEF);
    check("t6_val", 64'(r2.send_val), 1);
    check("t6_msg0", 64'(r2.send_msg[0]), 64'hDEAD);
    check("t6_msg1", 64'(r2.send_msg[1]), 64'hBEEF);
    r2.send_rdy = 1'b1;
    tick();
    check("t6_drop_val", 64'(r2.send_val), 0);
    r2.send_rdy = 1'b0;
    push2(32'h1234);
    push2(32'h5678);
    check("t6_f2_val", 64'(r2.send_val), 1);
    check("t6_f2_msg0", 64'(r2.send_msg[0]), 64'h1234);
    check("t6_f2_msg1", 64'(r2.send_msg[1]), 64'h5678);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
